// File: rtl/mvm_pkg.sv
// Shared types and helpers for the mvm_par matrix-vector multiplier.
// Holds the controller state encoding, default sizes, and the overflow-aware
// adder used by every MAC lane.
package mvm_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int NROWS_DEF     = 4;
    localparam int NCOLS_DEF     = 4;
    localparam int NUM_LANES_DEF = 2;
    localparam int IN_W_DEF      = 8;
    localparam int ACC_W_DEF     = 16;

    // Working width of sat_add; callers sign-extend into it and keep the low w bits.
    localparam int SAT_W = 64;

    // Adds two values that are meaningful in their low w bits. ovf flags a
    // signed overflow at width w (operands share a sign, the sum does not).
    // With sat set, an overflowing sum is replaced by the w-bit max or min.
    function automatic logic [SAT_W-1:0] sat_add(
        input  logic [SAT_W-1:0] a,
        input  logic [SAT_W-1:0] b,
        input  int unsigned      w,
        input  logic             sat,
        output logic             ovf
    );
        logic [SAT_W-1:0] sum;
        logic [SAT_W-1:0] max_v;
        sum   = a + b;
        ovf   = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
        max_v = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        if (sat && ovf) begin
            sum = a[w-1] ? ~max_v : max_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mvm_par_if.sv
// Stream interface of mvm_par: element input stream and result output stream.
// The slave modport is the multiplier's view; master is the source/sink side.
interface mvm_par_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  data_in;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [ACC_W-1:0] data_out;
    logic                    overflow;

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, overflow
    );

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, overflow
    );
endinterface

// File: rtl/mvm_mac_lane.sv
// One multiply-accumulate lane: operand register, product register, and an
// accumulator with sticky per-row overflow. Optional clamping is selected by
// the MVM_PAR_SAT_EN macro; by default the accumulator wraps.
module mvm_mac_lane
    import mvm_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue,
    input  logic                    first,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  x,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);

`ifdef MVM_PAR_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [IN_W-1:0]   a_p0;
    logic signed [IN_W-1:0]   x_p0;
    logic                     first_p0;
    logic                     vld_p0;
    logic signed [2*IN_W-1:0] prod_p1;
    logic                     first_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic                     ovf_p2;

    logic signed [ACC_W-1:0]  acc_base;
    logic [SAT_W-1:0]         sum_w;
    logic                     add_ovf;
    logic                     hold;
    logic                     unused_hi;

    // Valid bits and the sticky overflow flag are control and take the reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            ovf_p2 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            if (vld_p1) begin
                ovf_p2 <= first_p1 ? add_ovf : (ovf_p2 | add_ovf);
            end
        end
    end

    // Datapath registers: operands (p0), product (p1), accumulator (p2).
    always_ff @(posedge clk) begin
        a_p0     <= a;
        x_p0     <= x;
        first_p0 <= first;
        prod_p1  <= a_p0 * x_p0;
        first_p1 <= first_p0;
        if (vld_p1 && !hold) begin
            acc_p2 <= sum_w[ACC_W-1:0];
        end
    end

    // Accumulate step: a row starts from zero; a clamped row stays at its bound.
    always_comb begin
        acc_base = first_p1 ? '0 : acc_p2;
        hold     = SAT && ovf_p2 && !first_p1;
        sum_w    = sat_add(SAT_W'(acc_base), SAT_W'(prod_p1), ACC_W, SAT, add_ovf);
    end

    assign unused_hi = ^sum_w[SAT_W-1:ACC_W];
    assign acc       = acc_p2;
    assign ovf       = ovf_p2;

endmodule

// File: rtl/mvm_par.sv
// mvm_par: streams in an NROWS x NCOLS matrix (row-major) and an NCOLS vector,
// computes y = A*x with NUM_LANES parallel MAC lanes (one row per lane per
// group) and streams the NROWS results out in row order with overflow flags.
// Build option: define MVM_PAR_SAT_EN for saturating accumulation (default wraps).
module mvm_par
    import mvm_pkg::*;
#(
    parameter int NROWS     = NROWS_DEF,
    parameter int NCOLS     = NCOLS_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic      clk,
    input  logic      reset,
    mvm_par_if.slave  bus
);

    localparam int NGROUPS = NROWS / NUM_LANES;
    localparam int CW      = $clog2(NCOLS + 3);
    localparam int XW      = $clog2(NCOLS);
    localparam int LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int AW      = $clog2(NGROUPS * NCOLS);

    state_t state;
    state_t next_state;

    logic [CW-1:0] col_cnt;
    logic [LW-1:0] lane_cnt;
    logic [GW-1:0] grp_cnt;

    logic signed [IN_W-1:0]  bank [NUM_LANES][NGROUPS*NCOLS];
    logic signed [IN_W-1:0]  x_vec [NCOLS];
    logic signed [ACC_W-1:0] lane_acc [NUM_LANES];
    logic                    lane_ovf [NUM_LANES];
    logic signed [ACC_W-1:0] obuf_data [NUM_LANES];
    logic                    obuf_ovf [NUM_LANES];

    logic          in_fire;
    logic          out_fire;
    logic          col_last;
    logic          lane_last;
    logic          grp_last;
    logic          calc_done;
    logic          issue;
    logic [XW-1:0] rd_col;
    logic [AW-1:0] addr;

    assign bus.s_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign bus.m_valid  = (state == DRAIN);
    assign bus.data_out = obuf_data[lane_cnt];
    assign bus.overflow = obuf_ovf[lane_cnt];

    assign in_fire   = bus.s_valid && bus.s_ready;
    assign out_fire  = bus.m_valid && bus.m_ready;
    assign col_last  = (col_cnt == CW'(NCOLS - 1));
    assign lane_last = (lane_cnt == LW'(NUM_LANES - 1));
    assign grp_last  = (grp_cnt == GW'(NGROUPS - 1));
    assign calc_done = (col_cnt == CW'(NCOLS + 2));
    assign issue     = (state == COMPUTE) && (col_cnt < CW'(NCOLS));

    // Column index and bank address shared by matrix writes and compute reads.
    always_comb begin
        rd_col = (col_cnt < CW'(NCOLS)) ? col_cnt[XW-1:0] : '0;
        addr   = AW'(int'(grp_cnt) * NCOLS + int'(rd_col));
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: load A, load x, then compute/drain one group at a time.
    always_comb begin
        next_state = state;
        case (state)
            LOAD_A:  if (in_fire && col_last && lane_last && grp_last) next_state = LOAD_B;
            LOAD_B:  if (in_fire && col_last) next_state = COMPUTE;
            COMPUTE: if (calc_done) next_state = DRAIN;
            DRAIN:   if (out_fire && lane_last) next_state = grp_last ? LOAD_A : COMPUTE;
            default: next_state = LOAD_A;
        endcase
    end

    // Position counters; lane/group during loading track row mod / div NUM_LANES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt  <= '0;
            lane_cnt <= '0;
            grp_cnt  <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_fire) begin
                        if (col_last) begin
                            col_cnt <= '0;
                            if (lane_last) begin
                                lane_cnt <= '0;
                                grp_cnt  <= grp_last ? '0 : grp_cnt + GW'(1);
                            end else begin
                                lane_cnt <= lane_cnt + LW'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        col_cnt <= col_last ? '0 : col_cnt + CW'(1);
                    end
                end
                COMPUTE: begin
                    if (calc_done) begin
                        col_cnt  <= '0;
                        lane_cnt <= '0;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (lane_last) begin
                            lane_cnt <= '0;
                            grp_cnt  <= grp_last ? '0 : grp_cnt + GW'(1);
                        end else begin
                            lane_cnt <= lane_cnt + LW'(1);
                        end
                    end
                end
                default: begin
                    col_cnt  <= '0;
                    lane_cnt <= '0;
                    grp_cnt  <= '0;
                end
            endcase
        end
    end

    // Matrix banks and vector storage, written by accepted input elements.
    always_ff @(posedge clk) begin
        if (state == LOAD_A && in_fire) begin
            bank[lane_cnt][addr] <= bus.data_in;
        end
        if (state == LOAD_B && in_fire) begin
            x_vec[rd_col] <= bus.data_in;
        end
    end

    // Output buffer captures every lane's result once the group has finished.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                obuf_data[k] <= '0;
                obuf_ovf[k]  <= 1'b0;
            end
        end else if (state == COMPUTE && calc_done) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                obuf_data[k] <= lane_acc[k];
                obuf_ovf[k]  <= lane_ovf[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mvm_mac_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .issue (issue),
            .first (col_cnt == '0),
            .a     (bank[k][addr]),
            .x     (x_vec[rd_col]),
            .acc   (lane_acc[k]),
            .ovf   (lane_ovf[k])
        );
    end

endmodule

// File: tb/tb_mvm_par.sv
// Bench for mvm_par at default sizes: directed matrices, overflow, output
// back-pressure, randomized matrices and an asynchronous reset during compute.
module tb_mvm_par;
    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int NL   = 2;
    localparam int IW   = 8;
    localparam int AW   = 16;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;
`ifdef MVM_PAR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mvm_par_if #(.IN_W(IW), .ACC_W(AW)) bus ();

    mvm_par #(
        .NROWS(NR), .NCOLS(NC), .NUM_LANES(NL), .IN_W(IW), .ACC_W(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int A [NR][NC];
    int X [NC];
    int Y [NR];
    bit O [NR];

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: y[r] = sum_c A[r][c]*x[c] in ACC_W-bit signed arithmetic,
    // overflow sticky per row; wrap by default, clamp-and-hold when saturating.
    function automatic void model();
        for (int r = 0; r < NR; r++) begin
            int acc = 0;
            bit ov = 1'b0;
            for (int c = 0; c < NC; c++) begin
                int s;
                if (SAT && ov) continue;
                s = acc + A[r][c] * X[c];
                if (s > MAXV || s < MINV) begin
                    ov = 1'b1;
                    if (SAT) s = (s > MAXV) ? MAXV : MINV;
                    else if (s > MAXV) s = s - 65536;
                    else s = s + 65536;
                end
                acc = s;
            end
            Y[r] = acc;
            O[r] = ov;
        end
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    // Called and returns just after a falling edge.
    task automatic send(input int d, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(1, 0) == 1) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.data_in = IW'(d);
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) check_int("s_ready_wait", int'(bus.s_ready), 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic load(input bit gaps);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) send(A[r][c], gaps);
        for (int c = 0; c < NC; c++) send(X[c], gaps);
    endtask

    task automatic recv(input int r, input int stall);
        int t = 0;
        while (!bus.m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_int($sformatf("m_valid_y%0d", r), int'(bus.m_valid), 1);
        bus.m_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_int($sformatf("hold_valid_y%0d", r), int'(bus.m_valid), 1);
            check_int($sformatf("hold_data_y%0d", r), int'(bus.data_out), Y[r]);
        end
        bus.m_ready = 1'b1;
        check_int($sformatf("data_y%0d", r), int'(bus.data_out), Y[r]);
        check_int($sformatf("ovf_y%0d", r), int'(bus.overflow), int'(O[r]));
        @(negedge clk);
        bus.m_ready = 1'b0;
    endtask

    task automatic run(input bit gaps, input bit rstall);
        model();
        load(gaps);
        for (int r = 0; r < NR; r++) recv(r, rstall ? int'($urandom_range(3, 0)) : 0);
    endtask

    task automatic rand_matrix();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) A[r][c] = rnd8();
        for (int c = 0; c < NC; c++) X[c] = rnd8();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_int("rst_s_ready", int'(bus.s_ready), 1);
        check_int("rst_m_valid", int'(bus.m_valid), 0);
        check_int("rst_data_out", int'(bus.data_out), 0);
        check_int("rst_overflow", int'(bus.overflow), 0);
        reset = 1'b1;
        @(negedge clk);

        // Identity matrix, x = 1..4.
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) A[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < NC; c++) X[c] = c + 1;
        run(1'b0, 1'b0);
        check_int("ident_s_ready_after", int'(bus.s_ready), 1);

        // Mixed-sign matrix with input gaps.
        A[0] = '{1, 2, 3, 4};
        A[1] = '{-1, -1, -1, -1};
        A[2] = '{0, 0, 0, 5};
        A[3] = '{2, 0, 0, 0};
        run(1'b1, 1'b0);

        // Same matrix, first result held off for five cycles.
        model();
        load(1'b0);
        recv(0, 5);
        for (int r = 1; r < NR; r++) recv(r, 0);
        check_int("stall_s_ready_after", int'(bus.s_ready), 1);

        // Overflow row: all -128 against x all -128.
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) A[r][c] = (r == 0) ? -128 : ((r == c) ? 1 : 0);
        for (int c = 0; c < NC; c++) X[c] = -128;
        run(1'b0, 1'b0);

        // Randomized matrices with input gaps and output stalls.
        for (int n = 0; n < 3; n++) begin
            rand_matrix();
            run(1'b1, 1'b1);
        end

        // Asynchronous reset between clock edges while computing.
        rand_matrix();
        load(1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_int("midrst_m_valid", int'(bus.m_valid), 0);
        check_int("midrst_s_ready", int'(bus.s_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rand_matrix();
        run(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
